// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational multi-port lookup, registered dedup update, per-set flush sweep.
// Replacement is round-robin by default; define BTB_PLRU_EN for per-set tree pseudo-LRU.
module btb_assoc #(
    parameter int SETS        = 64,
    parameter int WAYS        = 4,
    parameter int TAGLEN      = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int TYPELEN     = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [32*FETCH_WIDTH-1:0]      fetch_pc,
    output logic [FETCH_WIDTH-1:0]         hit,
    output logic [32*FETCH_WIDTH-1:0]      target_pc,
    output logic [TYPELEN*FETCH_WIDTH-1:0] ins_type,
    input  logic                           upd_valid,
    input  logic [31:0]                    upd_pc,
    input  logic [31:0]                    upd_target,
    input  logic [TYPELEN-1:0]             upd_type,
    input  logic                           flush_req,
    output logic                           busy
);
    localparam int SI = $clog2(SETS);
    localparam int LW = $clog2(WAYS);
`ifdef BTB_PLRU_EN
    localparam int RW = WAYS - 1;
`else
    localparam int RW = LW;
`endif

    typedef enum logic {IDLE, SWEEP} state_t;

    logic [WAYS-1:0]    valid_q [SETS];
    logic [TAGLEN-1:0]  tag_q   [SETS][WAYS];
    logic [31:0]        tgt_q   [SETS][WAYS];
    logic [TYPELEN-1:0] type_q  [SETS][WAYS];
    logic [RW-1:0]      repl_q  [SETS];

    logic               stg_v;
    logic [31:0]        stg_pc;
    logic [31:0]        stg_target;
    logic [TYPELEN-1:0] stg_type;
    logic [SI-1:0]      stg_set;
    logic [TAGLEN-1:0]  stg_tag;
    logic               stg_hit;
    logic               has_inv;
    logic [LW-1:0]      hit_way;
    logic [LW-1:0]      inv_way;
    logic [LW-1:0]      victim;
    logic [LW-1:0]      wr_way;
    logic [RW-1:0]      repl_next;

    state_t             state_q, state_d;
    logic [SI-1:0]      fcnt_q, fcnt_d;

    function automatic logic [SI-1:0] set_of(input logic [31:0] pc);
        return pc[SI+1:2];
    endfunction

    // Bits above the index are folded in TAGLEN-wide slices; a short top slice is implicitly zero-extended.
    function automatic logic [TAGLEN-1:0] tag_of(input logic [31:0] pc);
        logic [TAGLEN-1:0] t;
        t = '0;
        for (int i = 2 + SI; i < 32; i++) t[(i - 2 - SI) % TAGLEN] ^= pc[i];
        return t;
    endfunction

`ifdef BTB_PLRU_EN
    // Heap-ordered tree: node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
    function automatic logic [RW-1:0] plru_touch(input logic [RW-1:0] t, input logic [LW-1:0] w);
        logic [RW-1:0] n;
        int            node;
        n    = t;
        node = 0;
        for (int l = 0; l < LW; l++) begin
            n[node] = ~w[LW-1-l];
            node    = 2 * node + (w[LW-1-l] ? 2 : 1);
        end
        return n;
    endfunction

    function automatic logic [LW-1:0] plru_victim(input logic [RW-1:0] t);
        int node;
        node = 0;
        for (int l = 0; l < LW; l++) node = 2 * node + (t[node] ? 2 : 1);
        return LW'(node - (WAYS - 1));
    endfunction
`endif

    always_comb begin
        hit       = '0;
        target_pc = '0;
        ins_type  = '0;
        for (int p = 0; p < FETCH_WIDTH; p++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (!busy && valid_q[set_of(fetch_pc[32*p +: 32])][w] &&
                    tag_q[set_of(fetch_pc[32*p +: 32])][w] == tag_of(fetch_pc[32*p +: 32])) begin
                    hit[p]                        = 1'b1;
                    target_pc[32*p +: 32]         = tgt_q[set_of(fetch_pc[32*p +: 32])][w];
                    ins_type[TYPELEN*p +: TYPELEN] = type_q[set_of(fetch_pc[32*p +: 32])][w];
                end
            end
        end
    end

    // Update stage: look up the registered PC against the live array and pick the way to write.
    assign stg_set = set_of(stg_pc);
    assign stg_tag = tag_of(stg_pc);

    always_comb begin
        stg_hit = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[stg_set][w] && tag_q[stg_set][w] == stg_tag) begin
                stg_hit = 1'b1;
                hit_way = LW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[stg_set][w]) begin
                has_inv = 1'b1;
                inv_way = LW'(w);
            end
        end
`ifdef BTB_PLRU_EN
        victim    = plru_victim(repl_q[stg_set]);
`else
        victim    = repl_q[stg_set];
`endif
        wr_way    = stg_hit ? hit_way : (has_inv ? inv_way : victim);
`ifdef BTB_PLRU_EN
        repl_next = plru_touch(repl_q[stg_set], wr_way);
`else
        repl_next = repl_q[stg_set] + 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) stg_v <= 1'b0;
        else       stg_v <= upd_valid && !busy;
    end

    always_ff @(posedge clk) begin
        if (upd_valid && !busy) begin
            stg_pc     <= upd_pc;
            stg_target <= upd_target;
            stg_type   <= upd_type;
        end
    end

    always_ff @(posedge clk) begin
        if (stg_v) begin
            tag_q[stg_set][wr_way]  <= stg_tag;
            tgt_q[stg_set][wr_way]  <= stg_target;
            type_q[stg_set][wr_way] <= stg_type;
        end
    end

    // The sweep clear is placed after the stage write so it wins when both touch the same set.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                repl_q[s]  <= '0;
            end
        end else begin
            if (stg_v) begin
                valid_q[stg_set][wr_way] <= 1'b1;
                repl_q[stg_set]          <= repl_next;
            end
            if (state_q == SWEEP) begin
                valid_q[fcnt_q] <= '0;
                repl_q[fcnt_q]  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = SWEEP;
                    fcnt_d  = '0;
                end
            end
            SWEEP: begin
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == SI'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SWEEP);

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage, serving `FETCH_WIDTH` lookup ports per cycle with combinational hit, target and type outputs. Corrections from the backend are captured in a registered update stage and written one cycle later, with deduplication against the live array. A flush sequencer invalidates the array one set per cycle. This block replaces the fixed 2-port, 2-way predictor table and adds selectable replacement.

## Interface

Parameters:
- `SETS`, 64: number of sets; power of two, at least 2.
- `WAYS`, 4: associativity; power of two, at least 2.
- `TAGLEN`, 8: stored tag width.
- `FETCH_WIDTH`, 2: number of lookup ports.
- `TYPELEN`, 3: instruction-type field width.

Ports (`SI = log2(SETS)`):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `fetch_pc`  in  32*FETCH_WIDTH  lookup PCs; port p is `[32p+31:32p]`.
- `hit`  out  FETCH_WIDTH  per-port hit.
- `target_pc`  out  32*FETCH_WIDTH  target on hit, else 0.
- `ins_type`  out  TYPELEN*FETCH_WIDTH  type on hit, else 0.
- `upd_valid`  in  1  write request (branch mispredicted).
- `upd_pc`  in  32  PC of the mispredicted branch.
- `upd_target`  in  32  correct target.
- `upd_type`  in  TYPELEN  correct type.
- `flush_req`  in  1  start full invalidation.
- `busy`  out  1  flush in progress.

## Operation

- Index and tag, for any PC:
  - `set = pc[SI+1:2]`.
  - `tag` = XOR-fold of `pc[31:2]` in `TAGLEN`-bit slices, starting at bit 2 + SI upward. The top slice is zero-extended.
- Lookup, per port and combinational:
  - A way hits when its valid bit is set and its stored tag equals the computed tag.
  - On multiple hits, the highest-numbered way wins; the update rule prevents this case.
  - While `busy`=1, every `hit` is 0, and `target_pc` and `ins_type` are 0.
- Update stage:
  - When `upd_valid`=1 and `busy`=0, register `{pc, target, type}` and set `stg_v`.
  - When `upd_valid`=1 and `busy`=1, the request is dropped.
  - The cycle after capture, the stage looks up its registered PC against the array and writes one way of its set, in priority order:
    1. The hitting way, if any: overwrite tag, target and type.
    2. Otherwise the lowest-numbered invalid way: fill it and set valid.
    3. Otherwise the replacement victim (see Configuration): fill it.
  - Every write advances the replacement state of that set.
- Back-to-back updates to the same PC:
  - The second update's lookup sees the first update's write.
  - It therefore hits the same way, so no duplicates are created.
- Flush FSM: states `IDLE`, `SWEEP`.
  - `IDLE` → `SWEEP` on `flush_req`. The set counter `fcnt` starts at 0.
  - In `SWEEP`, each cycle clears valid for all ways of set `fcnt`, clears that set's replacement state, and increments `fcnt`.
  - After clearing set `SETS-1`, return to `IDLE`.
  - `busy` = (state == `SWEEP`).
  - `flush_req` while `busy` is ignored.
  - If `stg_v` is pending when `flush_req` arrives, the pending write still completes in the same cycle that `SWEEP` begins. Set 0 is cleared in that cycle and the write is to the same array, so the flush clear takes priority for set 0 only.
- Reset:
  - All valid bits cleared.
  - All replacement state cleared.
  - `stg_v`=0, state `IDLE`, `fcnt`=0.
  - Tag, target and type arrays are not reset.
  - Reset outputs: `hit`=0, `target_pc`=0, `ins_type`=0, `busy`=0.
  - Reset asserted mid-sweep aborts the sweep; all valid bits are already cleared.

## Timing

- Lookup latency: 0 cycles, combinational from `fetch_pc`.
- Update visibility:
  - `upd_valid` in cycle 0 → stage loaded at the end of cycle 0.
  - Array written at the end of cycle 1.
  - A lookup hits from cycle 2.
- Throughput: one update per cycle, fully pipelined.
- Flush:
  - `flush_req` in cycle 0 → `busy`=1 in cycles 1 through `SETS`.
  - `busy`=0 in cycle `SETS`+1, when all entries are invalid.

## Configuration

- Macro `BTB_PLRU_EN` defined:
  - Per-set tree pseudo-LRU with `WAYS-1` bits.
  - Each write points the tree away from the written way.
  - The victim is found by following the tree bits from the root.
- Macro `BTB_PLRU_EN` undefined:
  - Per-set `log2(WAYS)`-bit round-robin counter.
  - The victim is `counter[set]`.
  - The counter increments (wrapping) on every write to that set.

## Test plan

- Reset, then lookup pc 0x1C000100 → `hit`=0, `target_pc`=0, `ins_type`=0, `busy`=0.
- Update pc 0x1C000100 with target 0x1C000200, type 3'b010 in cycle 0 → port 0 hits with that target and type from cycle 2. Port 1 on the same PC also hits.
- Five distinct PCs mapping to one set (`WAYS`=4):
  - The first four fill ways 0-3.
  - The fifth evicts way 0 under round-robin.
  - With `BTB_PLRU_EN`, after the write order 0,1,2,3 the fifth also evicts way 0.
  - The evicted PC then misses.
- Two back-to-back updates to the same PC with targets 0xA0 then 0xB0 → a single valid way holds 0xB0; the other ways are unchanged.
- Fill several sets, then pulse `flush_req` → `busy` high for exactly `SETS` cycles and all lookups miss during it. An `upd_valid` issued during `busy` is lost, and every lookup misses after `busy` falls.
- Assert `reset` mid-sweep → next cycle `busy`=0, all lookups miss, and an update then behaves normally.
